// File: rtl/sccb_responder.sv
// SCCB write responder: ACKs DEV_ADDR and emits one wr_en per dev/reg/data write.
// Define SCCB_READ_EN to also answer DEV_ADDR|1 reads, using rd_en/rd_data.
`timescale 1ns/1ps
module sccb_responder #(
  parameter logic [7:0] DEV_ADDR    = 8'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sioc,
  input  logic       siod,
  output logic       siod_oe,
  output logic       busy,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_en,
  input  logic [7:0] rd_data
);

  typedef enum logic [2:0] {IDLE, RX_DEV, RX_REG, RX_DATA, ACK, NACK_WAIT, TX_DATA} state_t;

  logic [SYNC_STAGES-1:0] sioc_sync, siod_sync;
  logic                   sioc_d, siod_d;
  logic                   sioc_s, siod_s;
  logic                   scl_rise, scl_fall, start_c, stop_c;

  state_t     state, ack_next;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;

  // NOTE: synchronizers reset to the idle bus level (1) so releasing reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sioc_sync <= '1;
      siod_sync <= '1;
      sioc_d    <= 1'b1;
      siod_d    <= 1'b1;
    end else begin
      sioc_sync <= {sioc_sync[SYNC_STAGES-2:0], sioc};
      siod_sync <= {siod_sync[SYNC_STAGES-2:0], siod};
      sioc_d    <= sioc_sync[SYNC_STAGES-1];
      siod_d    <= siod_sync[SYNC_STAGES-1];
    end
  end

  assign sioc_s   = sioc_sync[SYNC_STAGES-1];
  assign siod_s   = siod_sync[SYNC_STAGES-1];
  assign scl_rise = sioc_s & ~sioc_d;
  assign scl_fall = ~sioc_s & sioc_d;
  // START/STOP require sioc to be high and unchanged in both samples.
  assign start_c  = sioc_s & sioc_d & siod_d & ~siod_s;
  assign stop_c   = sioc_s & sioc_d & ~siod_d & siod_s;

`ifdef SCCB_READ_EN
  logic       rd_cap;
  logic [7:0] tx_sh;
`else
  logic unused_rd;
  assign unused_rd = ^rd_data;
  assign rd_en     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ack_next <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      siod_oe  <= 1'b0;
      busy     <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
`ifdef SCCB_READ_EN
      rd_en    <= 1'b0;
      rd_cap   <= 1'b0;
      tx_sh    <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
`ifdef SCCB_READ_EN
      rd_en  <= 1'b0;
      rd_cap <= rd_en;
      if (rd_cap) tx_sh <= rd_data;
`endif
      if (stop_c) begin
        state   <= IDLE;
        busy    <= 1'b0;
        siod_oe <= 1'b0;
      end else if (start_c) begin
        state   <= RX_DEV;
        busy    <= 1'b1;
        siod_oe <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          RX_DEV, RX_REG, RX_DATA: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shreg   <= {shreg[6:0], siod_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              case (state)
                RX_DEV: begin
                  if (shreg == DEV_ADDR) begin
                    siod_oe  <= 1'b1;
                    state    <= ACK;
                    ack_next <= RX_REG;
`ifdef SCCB_READ_EN
                  end else if (shreg == (DEV_ADDR | 8'h01)) begin
                    siod_oe  <= 1'b1;
                    rd_en    <= 1'b1;
                    state    <= ACK;
                    ack_next <= TX_DATA;
`endif
                  end else begin
                    state <= NACK_WAIT;
                  end
                end
                RX_REG: begin
                  wr_addr  <= shreg;
                  siod_oe  <= 1'b1;
                  state    <= ACK;
                  ack_next <= RX_DATA;
                end
                default: begin
                  wr_data  <= shreg;
                  wr_en    <= 1'b1;
                  siod_oe  <= 1'b1;
                  state    <= ACK;
                  ack_next <= NACK_WAIT;
                end
              endcase
            end
          end
          ACK: begin
            if (scl_fall) begin
              siod_oe <= 1'b0;
              state   <= ack_next;
`ifdef SCCB_READ_EN
              if (ack_next == TX_DATA) begin
                siod_oe <= ~tx_sh[7];
                tx_sh   <= {tx_sh[6:0], 1'b0};
                bit_cnt <= 4'd1;
              end
`endif
            end
          end
`ifdef SCCB_READ_EN
          TX_DATA: begin
            if (scl_fall) begin
              if (bit_cnt < 4'd8) begin
                siod_oe <= ~tx_sh[7];
                tx_sh   <= {tx_sh[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end else begin
                // Release for the master's ACK slot; its answer is not used.
                siod_oe <= 1'b0;
                state   <= NACK_WAIT;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_responder.sv
// Bench for sccb_responder: open-drain SCCB master model at ~100 kHz, 25 MHz clk,
// write scoreboard checked by an independent wr_en/rd_en monitor.
`timescale 1ns/1ps
module tb_sccb_responder;
  localparam int Q    = 62;  // quarter SCCB bit in clk cycles
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset, sioc, siod_m;
  logic [7:0] rd_data;
  wire        siod_bus;
  logic       siod_oe, busy, wr_en, rd_en;
  logic [7:0] wr_addr, wr_data;

  always #20 clk = ~clk;
  assign siod_bus = siod_m & ~siod_oe;

  sccb_responder #(.DEV_ADDR(8'h42), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .sioc(sioc), .siod(siod_bus), .siod_oe(siod_oe),
    .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data)
  );

  typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;
  wr_t exp_q[$];

  int errors = 0, checks = 0;
  int cyc = 0, last_fall = 0, wr_count = 0, rd_count = 0;
  bit oe_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every write strobe, independent of stimulus.
  always @(negedge clk) begin
    if (siod_oe) oe_seen = 1'b1;
    if (!reset && wr_en) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr: got addr 0x%0h data 0x%0h, no write expected", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
        check("wr_latency", cyc - last_fall, SYNC + 1);
      end
    end
    if (!reset && rd_en) begin
      rd_count++;
      check("rd_addr", wr_addr, 8'h0A);
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    siod_m = 1'b0; qwait();
    sioc   = 1'b0; qwait();
  endtask

  task automatic rep_start();
    siod_m = 1'b1; qwait();
    sioc   = 1'b1; qwait();
    siod_m = 1'b0; qwait();
    sioc   = 1'b0; qwait();
  endtask

  task automatic bus_stop();
    siod_m = 1'b0; qwait();
    sioc   = 1'b1; qwait();
    siod_m = 1'b1; qwait();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    logic [7:0] v;
    v = b;
    for (int i = 0; i < n; i++) begin
      siod_m = v[7 - i]; qwait();
      sioc = 1'b1; qwait(); qwait();
      sioc = 1'b0; last_fall = cyc; qwait();
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    siod_m = 1'b1; qwait();
    sioc = 1'b1; qwait();
    ack = ~siod_bus; qwait();
    sioc = 1'b0; qwait();
  endtask

  task automatic read_byte(output logic [7:0] b);
    siod_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      qwait();
      sioc = 1'b1; qwait();
      b[i] = siod_bus; qwait();
      sioc = 1'b0; qwait();
    end
    qwait();                       // master NACK slot
    sioc = 1'b1; qwait(); qwait();
    sioc = 1'b0; qwait();
  endtask

  task automatic full_write(input string tag, input logic [7:0] ra, input logic [7:0] rd,
                            input bit do_start);
    logic ack;
    exp_q.push_back('{addr: ra, data: rd});
    if (do_start) bus_start();
    write_byte(8'h42, ack); check({tag, "_ack_dev"}, ack, 1'b1);
    write_byte(ra, ack);    check({tag, "_ack_reg"}, ack, 1'b1);
    write_byte(rd, ack);    check({tag, "_ack_data"}, ack, 1'b1);
    bus_stop();
    check({tag, "_busy_after_stop"}, busy, 1'b0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rx;
    reset = 1'b1; sioc = 1'b1; siod_m = 1'b1; rd_data = 8'h76;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_siod_oe", siod_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_wr_addr", wr_addr, 8'h00);
    check("rst_wr_data", wr_data, 8'h00);

    // Basic write 0x12 = 0x80
    bus_start();
    check("t1_busy_after_start", busy, 1'b1);
    full_write("t1", 8'h12, 8'h80, 1'b0);
    check("t1_wr_count", wr_count, 1);

    // Foreign device address: never driven, no write
    oe_seen = 1'b0;
    bus_start();
    write_byte(8'h60, ack); check("t2_nack_dev", ack, 1'b0);
    write_byte(8'h12, ack); check("t2_nack_reg", ack, 1'b0);
    bus_stop();
    check("t2_oe_never", oe_seen, 1'b0);
    check("t2_wr_count", wr_count, 1);

    // Dev + reg only, then STOP
    bus_start();
    write_byte(8'h42, ack); check("t3_ack_dev", ack, 1'b1);
    write_byte(8'h3A, ack); check("t3_ack_reg", ack, 1'b1);
    bus_stop();
    check("t3_busy", busy, 1'b0);
    check("t3_wr_count", wr_count, 1);
    check("t3_wr_addr_latched", wr_addr, 8'h3A);

    // Reset during the ACK slot of the reg byte
    bus_start();
    write_byte(8'h42, ack); check("t4_ack_dev", ack, 1'b1);
    send_bits(8'h33, 8);
    siod_m = 1'b1; qwait();
    check("t4_oe_in_ack", siod_oe, 1'b1);
    sioc = 1'b1; qwait();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t4_oe_after_reset", siod_oe, 1'b0);
    check("t4_busy_after_reset", busy, 1'b0);
    qwait();
    sioc = 1'b0; qwait();
    bus_stop();
    full_write("t4b", 8'h11, 8'h01, 1'b1);
    check("t4_wr_count", wr_count, 2);

    // Repeated START after 4 data bits; only the second write lands
    bus_start();
    write_byte(8'h42, ack); check("t5_ack_dev", ack, 1'b1);
    write_byte(8'h20, ack); check("t5_ack_reg", ack, 1'b1);
    send_bits(8'hF0, 4);
    rep_start();
    check("t5_busy_rep_start", busy, 1'b1);
    full_write("t5b", 8'h15, 8'h02, 1'b0);
    check("t5_wr_count", wr_count, 3);

`ifdef SCCB_READ_EN
    bus_start();
    write_byte(8'h42, ack); check("t6_ack_dev", ack, 1'b1);
    write_byte(8'h0A, ack); check("t6_ack_reg", ack, 1'b1);
    bus_stop();
    bus_start();
    write_byte(8'h43, ack); check("t6_ack_rd_dev", ack, 1'b1);
    read_byte(rx);
    bus_stop();
    check("t6_rd_byte", rx, 8'h76);
    check("t6_rd_count", rd_count, 1);
    check("t6_busy", busy, 1'b0);
`else
    bus_start();
    write_byte(8'h43, ack); check("t6_nack_rd_dev", ack, 1'b0);
    bus_stop();
    check("t6_rd_count", rd_count, 0);
    check("t6_busy", busy, 1'b0);
`endif

    repeat (10) @(negedge clk);
    check("final_wr_count", wr_count, 3);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
